load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the byte-enable data memory. Takes RV32I load/store requests
//  (LB/LH/LW/LBU/LHU/SB/SH/SW), drives memory addr/wd/wen/ren, then aligns and
//  sign-/zero-extends read data. Sits between the execute stage and the data memory.
//  The memory decodes only wen = 0001/0010/0100/1000/0011/0111/1111, so an upper-halfword
//  store is done as a read-modify-write (RMW) sequence.
// PARAMETERS
//  RMW_HI_HALF  1  1: SH at offset 2 is done as an RMW; 0: issue wen=1100 directly
//  ERR_ILLEGAL  1  1: funct3 011/110/111 raises o_err; 0: treated as W
// PORTS
//  i_clk      in   1   single clock, rising edge
//  i_rst      in   1   synchronous, active-high reset
//  i_req      in   1   request strobe, sampled only in IDLE
//  i_we       in   1   1=store, 0=load
//  i_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr     in   32  byte address
//  i_wdata    in   32  store data, right-aligned
//  o_rdata    out  32  extended load result, held until the next load completes
//  o_done     out  1   one-cycle completion pulse
//  o_err      out  1   valid with o_done: misaligned or illegal access, no memory access made
//  o_busy     out  1   0 only in IDLE
//  o_dm_addr  out  32  byte address to memory (memory does the >>2)
//  o_dm_wd    out  32  lane-shifted write data
//  o_dm_wen   out  4   byte-lane write enables
//  o_dm_ren   out  1   read enable; never high together with o_dm_wen!=0
//  i_dm_rd    in   32  memory read word, valid one cycle after o_dm_ren
// BEHAVIOUR
//  Reset: state=IDLE; every output 0, including o_rdata. Reset in any state aborts the
//   operation. No wen is driven in the reset cycle or after it; any write already done stays.
//  Accept: in IDLE with i_req=1, latch we/funct3/addr/wdata. Requests while busy are ignored.
//  Error: H with addr[0]=1, W with addr[1:0]!=0, or illegal funct3 -> go to RESP with err.
//  FSM (memory signals decoded from state + latched regs; o_done/o_err registered):
//   IDLE   -> ISSUE (legal request) | RESP (error) | IDLE
//   ISSUE  load or RMW: ren=1 -> RDWAIT. Plain store: wen=mask, wd=shifted -> RESP
//   RDWAIT load: o_rdata<=extract(i_dm_rd) -> RESP. RMW: merge<={wdata[15:0],rd[15:0]} -> RMW_WR
//   RMW_WR wen=1111, wd=merge -> RESP
//   RESP   o_done=1, o_err=err flag -> IDLE
//  Latency, request accepted in cycle 0: o_done in cycle 1 (error), 2 (store), 3 (load),
//   4 (RMW store).
//  Masks: SB offset k -> 1<<k, wd=wdata<<8k. SH offset 0 -> 0011. SH offset 2 -> RMW,
//   or 1100 with wd=wdata<<16 when RMW_HI_HALF=0. SW -> 1111.
//  Extract: byte = rd>>8*addr[1:0], half = rd>>16*addr[1]. B/H sign-extend, BU/HU zero-extend.
//  Address: o_dm_addr = latched addr, unmodified. o_dm_wd = 0 when wen=0.
// STRUCTURE
//  Shared package/defines: funct3 codes, state encoding, wen mask constants (WEN_B0..WEN_W).
//  Sub-module: lsu_load_align (combinational extract + extend). FSM and datapath stay in the top.
// TESTING  (memory word @0x10 = 0x8899AABB; request in cycle 0)
//  LB 0x13 -> o_rdata=0xFFFFFF88, o_done in cycle 3; LBU 0x12 -> 0x00000099.
//  SB 0x11, wdata=0x000000CC -> cycle 1 wen=0010, wd=0x0000CC00; done cycle 2;
//   word becomes 0x8899CCBB.
//  SH 0x12, wdata=0x00001234 -> cycle 1 ren=1; cycle 3 wen=1111, wd=0x1234AABB; done cycle 4.
//  LW 0x12 and funct3=011 @0x10 -> o_done=o_err=1 in cycle 1; ren/wen never asserted.
//  Reset in RDWAIT of an RMW SH -> no wen issued, all outputs 0 next cycle; then
//   LW 0x10 returns 0x8899AABB.
//  i_req held high through an LW -> next request accepted only in the cycle after RESP;
//   o_busy stays 1 from cycle 1 through RESP.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, byte-lane
// write-enable patterns and small funct3 decode helpers.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] WEN_B0 = 4'b0001;
    localparam logic [3:0] WEN_B1 = 4'b0010;
    localparam logic [3:0] WEN_B2 = 4'b0100;
    localparam logic [3:0] WEN_B3 = 4'b1000;
    localparam logic [3:0] WEN_H0 = 4'b0011;
    localparam logic [3:0] WEN_H1 = 4'b1100;
    localparam logic [3:0] WEN_W  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ISSUE, ST_RDWAIT, ST_RMW_WR, ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Illegal codes (x11, 110) fall into the word size, which is what the
    // non-erroring configuration wants.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load-data alignment: picks the addressed byte/halfword out of the
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_rd,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = i_rd[{i_off, 3'b000} +: 8];
    assign half_sel = i_rd[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_data = {24'b0, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_data = {16'b0, half_sel};
            default: o_data = i_rd;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a byte-enable data memory. Upper-halfword stores are
// done as read-modify-write because the memory does not decode wen=1100.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit RMW_HI_HALF = 1'b1,
    parameter bit ERR_ILLEGAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic        o_busy,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wd,
    output logic [3:0]  o_dm_wen,
    output logic        o_dm_ren,
    input  logic [31:0] i_dm_rd
);
    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] rd_aligned;
    logic        req_bad;
    logic        is_rmw;
    logic [3:0]  st_wen;
    logic [31:0] st_wd;

    lsu_load_align u_align (
        .i_rd     (i_dm_rd),
        .i_off    (addr_q[1:0]),
        .i_funct3 (funct3_q),
        .o_data   (rd_aligned)
    );

    always_comb begin
        req_bad = 1'b0;
        case (f3_size(i_funct3))
            SZ_H:    req_bad = i_addr[0];
            SZ_W:    req_bad = (i_addr[1:0] != 2'b00);
            default: req_bad = 1'b0;
        endcase
        if (ERR_ILLEGAL && f3_illegal(i_funct3)) req_bad = 1'b1;
    end

    assign is_rmw = RMW_HI_HALF && we_q && (f3_size(funct3_q) == SZ_H) && addr_q[1];

    always_comb begin
        st_wen = WEN_W;
        st_wd  = wdata_q;
        case (f3_size(funct3_q))
            SZ_B: begin
                st_wd = {24'b0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                case (addr_q[1:0])
                    2'd0:    st_wen = WEN_B0;
                    2'd1:    st_wen = WEN_B1;
                    2'd2:    st_wen = WEN_B2;
                    default: st_wen = WEN_B3;
                endcase
            end
            SZ_H: begin
                st_wd  = {16'b0, wdata_q[15:0]} << {addr_q[1], 4'b0000};
                st_wen = addr_q[1] ? WEN_H1 : WEN_H0;
            end
            default: ;
        endcase
    end

    // Memory strobes are gated by reset so an aborted RMW never writes in the reset cycle.
    always_comb begin
        o_dm_ren = 1'b0;
        o_dm_wen = 4'b0000;
        o_dm_wd  = 32'b0;
        if (!i_rst) begin
            case (state_q)
                ST_ISSUE: begin
                    if (!we_q || is_rmw) begin
                        o_dm_ren = 1'b1;
                    end else begin
                        o_dm_wen = st_wen;
                        o_dm_wd  = st_wd;
                    end
                end
                ST_RMW_WR: begin
                    o_dm_wen = WEN_W;
                    o_dm_wd  = merge_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    we_d     = i_we;
                    funct3_d = i_funct3;
                    addr_d   = i_addr;
                    wdata_d  = i_wdata;
                    state_d  = req_bad ? ST_RESP : ST_ISSUE;
                    done_d   = req_bad;
                    err_d    = req_bad;
                end
            end
            ST_ISSUE: begin
                if (!we_q || is_rmw) begin
                    state_d = ST_RDWAIT;
                end else begin
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (!we_q) begin
                    rdata_d = rd_aligned;
                    state_d = ST_RESP;
                    done_d  = 1'b1;
                end else begin
                    merge_d = {wdata_q[15:0], i_dm_rd[15:0]};
                    state_d = ST_RMW_WR;
                end
            end
            ST_RMW_WR: begin
                state_d = ST_RESP;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            merge_q  <= 32'b0;
            rdata_q  <= 32'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_rdata   = rdata_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_dm_addr = addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single operations against a
// small byte-enable memory model, plus reset-abort and held-request sequences.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst, i_req, i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic [31:0] o_rdata, o_dm_addr, o_dm_wd;
    logic        o_done, o_err, o_busy, o_dm_ren;
    logic [3:0]  o_dm_wen;
    logic [31:0] i_dm_rd;

    load_store_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .o_dm_addr(o_dm_addr), .o_dm_wd(o_dm_wd), .o_dm_wen(o_dm_wen),
        .o_dm_ren(o_dm_ren), .i_dm_rd(i_dm_rd)
    );

    initial forever #5 i_clk = ~i_clk;

    // Memory model: read data one cycle after ren, byte-lane writes, bench preload port.
    logic [31:0] mem [0:15];
    logic        ld_en;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;

    always @(posedge i_clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        if (o_dm_ren) i_dm_rd <= mem[o_dm_addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (o_dm_wen[b]) mem[o_dm_addr[5:2]][8*b +: 8] <= o_dm_wd[8*b +: 8];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] idx, input logic [31:0] val);
        ld_en = 1'b1; ld_idx = idx; ld_val = val;
        @(posedge i_clk); #1;
        ld_en = 1'b0;
    endtask

    // Results of the last run_op
    int          r_lat;
    logic        r_err, r_ren, r_proto_ok;
    logic [3:0]  r_wen;
    logic [31:0] r_wd;

    task automatic run_op(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        r_lat = 0; r_err = 1'b0; r_ren = 1'b0; r_wen = 4'h0; r_wd = 32'h0; r_proto_ok = 1'b1;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (o_dm_ren) r_ren = 1'b1;
            if (o_dm_wen != 4'h0) begin
                r_wen = o_dm_wen; r_wd = o_dm_wd;
                if (!(o_dm_wen inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h7, 4'hF})) r_proto_ok = 1'b0;
                if (o_dm_ren) r_proto_ok = 1'b0;
            end else if (o_dm_wd != 32'h0) r_proto_ok = 1'b0;
            if ((o_dm_ren || o_dm_wen != 4'h0) && o_dm_addr != addr) r_proto_ok = 1'b0;
            if (!o_busy) r_proto_ok = 1'b0;
            if (o_done) begin
                r_lat = c; r_err = o_err;
                break;
            end
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic        err;
        int          lat;
        logic        ren;
        logic [3:0]  wen;
        logic [31:0] wd, word;
    } vec_t;

    localparam logic [31:0] W0 = 32'h8899AABB;
    vec_t vecs [20];
    logic [31:0] last_ld;

    initial begin
        //            we    f3      addr    wdata         rdata         err lat ren  wen   wd            word
        vecs[0]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[1]  = '{1'b0, 3'b100, 32'h12, 32'h0,        32'h00000099, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[2]  = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFBB, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[3]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[4]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFAABB, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[5]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h00008899, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[6]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[7]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 3, 1'b1, 4'h0, 32'h0,        W0};
        vecs[8]  = '{1'b1, 3'b000, 32'h11, 32'h000000CC, 32'h0,        1'b0, 2, 1'b0, 4'h2, 32'h0000CC00, 32'h8899CCBB};
        vecs[9]  = '{1'b1, 3'b000, 32'h13, 32'h12345677, 32'h0,        1'b0, 2, 1'b0, 4'h8, 32'h77000000, 32'h7799AABB};
        vecs[10] = '{1'b1, 3'b000, 32'h10, 32'h000000EE, 32'h0,        1'b0, 2, 1'b0, 4'h1, 32'h000000EE, 32'h8899AAEE};
        vecs[11] = '{1'b1, 3'b001, 32'h10, 32'h00001234, 32'h0,        1'b0, 2, 1'b0, 4'h3, 32'h00001234, 32'h88991234};
        vecs[12] = '{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0, 4, 1'b1, 4'hF, 32'h1234AABB, 32'h1234AABB};
        vecs[13] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b0, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};
        vecs[15] = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};
        vecs[16] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};
        vecs[17] = '{1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};
        vecs[18] = '{1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};
        vecs[19] = '{1'b1, 3'b110, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 1'b0, 4'h0, 32'h0,        W0};

        i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000;
        i_addr = 32'h0; i_wdata = 32'h0; ld_en = 1'b0; ld_idx = 4'h0; ld_val = 32'h0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        chk("reset rdata", o_rdata, 32'h0);
        chk("reset done/err/busy/ren", {28'h0, o_done, o_err, o_busy, o_dm_ren}, 32'h0);
        chk("reset wen", {28'h0, o_dm_wen}, 32'h0);
        chk("reset dm_addr", o_dm_addr, 32'h0);
        chk("reset dm_wd", o_dm_wd, 32'h0);

        last_ld = 32'h0;
        for (int v = 0; v < 20; v++) begin
            load_word(4'd4, W0);
            run_op(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata);
            chk($sformatf("v%0d latency", v), r_lat, vecs[v].lat);
            chk($sformatf("v%0d err", v), {31'h0, r_err}, {31'h0, vecs[v].err});
            chk($sformatf("v%0d ren", v), {31'h0, r_ren}, {31'h0, vecs[v].ren});
            chk($sformatf("v%0d wen", v), {28'h0, r_wen}, {28'h0, vecs[v].wen});
            if (vecs[v].wen != 4'h0) chk($sformatf("v%0d wd", v), r_wd, vecs[v].wd);
            chk($sformatf("v%0d protocol", v), {31'h0, r_proto_ok}, 32'h1);
            chk($sformatf("v%0d mem word", v), mem[4], vecs[v].word);
            if (!vecs[v].err) begin
                if (!vecs[v].we) last_ld = vecs[v].rdata;
                chk($sformatf("v%0d rdata", v), o_rdata, last_ld);
            end
        end

        // Request held high through a load; the changed store inputs must wait for IDLE.
        load_word(4'd4, W0);
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h10; i_wdata = 32'h0;
        @(posedge i_clk); #1;
        i_we = 1'b1; i_wdata = 32'h11223344;
        chk("held c1 busy", {31'h0, o_busy}, 32'h1);
        @(posedge i_clk); #1;
        chk("held c2 busy", {31'h0, o_busy}, 32'h1);
        @(posedge i_clk); #1;
        chk("held c3 busy/done", {30'h0, o_busy, o_done}, 32'h3);
        chk("held c3 rdata", o_rdata, W0);
        @(posedge i_clk); #1;
        chk("held c4 busy", {31'h0, o_busy}, 32'h0);
        chk("held c4 mem untouched", mem[4], W0);
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("held c5 busy/wen", {27'h0, o_busy, o_dm_wen}, {27'h0, 1'b1, 4'hF});
        @(posedge i_clk); #1;
        chk("held c6 done", {31'h0, o_done}, 32'h1);
        @(posedge i_clk); #1;
        chk("held store word", mem[4], 32'h11223344);

        // Reset while an RMW halfword store is in RDWAIT: no write, all outputs cleared.
        load_word(4'd4, W0);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h12; i_wdata = 32'h00005678;
        @(posedge i_clk); #1;
        i_req = 1'b0;
        chk("rst-rmw c1 ren", {31'h0, o_dm_ren}, 32'h1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        #1 chk("rst-rmw reset-cycle wen", {28'h0, o_dm_wen}, 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst-rmw rdata", o_rdata, 32'h0);
        chk("rst-rmw ctl", {27'h0, o_done, o_err, o_busy, o_dm_ren, |o_dm_wen}, 32'h0);
        chk("rst-rmw addr", o_dm_addr, 32'h0);
        chk("rst-rmw wd", o_dm_wd, 32'h0);
        begin
            logic wen_seen;
            wen_seen = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (o_dm_wen != 4'h0) wen_seen = 1'b1;
                @(posedge i_clk); #1;
            end
            chk("rst-rmw no later wen", {31'h0, wen_seen}, 32'h0);
        end
        chk("rst-rmw mem intact", mem[4], W0);
        run_op(1'b0, 3'b010, 32'h10, 32'h0);
        chk("post-reset LW latency", r_lat, 3);
        chk("post-reset LW rdata", o_rdata, W0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
